// File: rtl/button_event_decoder.sv
// button_event_decoder
//
// Turns a clean, clock-synchronous button level into single-cycle events for
// the game logic: a press pulse, a release pulse, and auto-repeat pulses
// while the button stays down. Also keeps a wrapping 8-bit press counter.
//
// The FSM has three states:
//   IDLE   : button up, waiting for a rising edge.
//   HOLD   : button down, counting towards the first repeat.
//   REPEAT : button down, emitting a repeat every REPEAT_PERIOD cycles.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   level         debounced button level, synchronous to clk
//   press_pulse   one-cycle pulse on press
//   release_pulse one-cycle pulse on release
//   repeat_pulse  one-cycle pulse per auto-repeat tick
//   held          high while in HOLD or REPEAT
//   press_count   number of presses, modulo 256
//   state_dbg     current FSM state (00 IDLE, 01 HOLD, 10 REPEAT)
//
// All outputs are registered.
module button_event_decoder #(
  parameter int HOLD_DELAY    = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    REPEAT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] counter, counter_n;
  logic             level_d;
  logic             press_n, release_n, repeat_n, held_n;
  logic [7:0]       press_count_n;
  logic             rise;

  // level_d resets high so a button already down at reset release is not
  // reported as a press; it has to go up and come down again first.
  assign rise      = level & ~level_d;
  assign state_dbg = state;

  always_comb begin
    state_n       = state;
    counter_n     = counter;
    press_n       = 1'b0;
    release_n     = 1'b0;
    repeat_n      = 1'b0;
    held_n        = held;
    press_count_n = press_count;

    case (state)
      IDLE: begin
        if (rise) begin
          press_n       = 1'b1;
          press_count_n = press_count + 8'd1;
          counter_n     = '0;
          held_n        = 1'b1;
          state_n       = HOLD;
        end
      end

      // Release is checked before the terminal count so that a release on
      // the terminal edge suppresses the repeat.
      HOLD: begin
        if (!level) begin
          release_n = 1'b1;
          held_n    = 1'b0;
          counter_n = '0;
          state_n   = IDLE;
        end else if (counter == HOLD_LAST) begin
          repeat_n  = 1'b1;
          counter_n = '0;
          state_n   = REPEAT;
        end else begin
          counter_n = counter + 1'b1;
        end
      end

      REPEAT: begin
        if (!level) begin
          release_n = 1'b1;
          held_n    = 1'b0;
          counter_n = '0;
          state_n   = IDLE;
        end else if (counter == REPEAT_LAST) begin
          repeat_n  = 1'b1;
          counter_n = '0;
        end else begin
          counter_n = counter + 1'b1;
        end
      end

      // Unused encoding: fall back to IDLE quietly.
      default: begin
        held_n    = 1'b0;
        counter_n = '0;
        state_n   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      level_d       <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_n;
      counter       <= counter_n;
      level_d       <= level;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      repeat_pulse  <= repeat_n;
      held          <= held_n;
      press_count   <= press_count_n;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed testbench for button_event_decoder with HOLD_DELAY=8 and
// REPEAT_PERIOD=4. Inputs change 1 ns after a rising edge; outputs are
// checked at the same point, so each tick() shows the result of one edge.
module tb_button_event_decoder;

  localparam int HOLD_DELAY    = 8;
  localparam int REPEAT_PERIOD = 4;
  localparam int CNT_W         = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       level = 1'b1;
  logic       press_pulse, release_pulse, repeat_pulse, held;
  logic [7:0] press_count;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  button_event_decoder #(
    .HOLD_DELAY   (HOLD_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .press_count  (press_count),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_err    = 0;
  int         press_seen = 0;
  int         release_seen = 0;
  logic [7:0] exp_count = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse counting and exclusivity on every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      if (press_pulse)   press_seen++;
      if (release_pulse) release_seen++;
      check("pulse_exclusive",
            32'(int'(press_pulse) + int'(release_pulse) + int'(repeat_pulse) <= 1), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic p, input logic r,
                            input logic rp, input logic h);
    check({tag, "_press"},   32'(press_pulse),   32'(p));
    check({tag, "_release"}, 32'(release_pulse), 32'(r));
    check({tag, "_repeat"},  32'(repeat_pulse),  32'(rp));
    check({tag, "_held"},    32'(held),          32'(h));
  endtask

  // Raise level for one sampled edge; the press pulse follows.
  task automatic press_edge();
    level = 1'b1;
    tick();
    exp_count = exp_count + 8'd1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    repeat (3) tick();
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_count", 32'(press_count), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));

    // Release reset with the button already down: no press for 20 cycles.
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out("high_at_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("high_at_reset_count", 32'(press_count), 32'd0);

    // Low for 2 cycles then high: exactly one press.
    level = 1'b0;
    tick();
    tick();
    press_edge();
    expect_out("first_press", 1'b1, 1'b0, 1'b0, 1'b1);
    check("first_press_count", 32'(press_count), 32'(exp_count));
    tick();
    expect_out("first_press_after", 1'b0, 1'b0, 1'b0, 1'b1);
    level = 1'b0;
    tick();
    expect_out("first_release", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Short press: 3 cycles high -> release at t+3, no repeat.
    press_edge();
    expect_out("short_t0", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("short_t1", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("short_t2", 1'b0, 1'b0, 1'b0, 1'b1);
    level = 1'b0;
    tick();
    expect_out("short_t3", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("short_t4", 1'b0, 1'b0, 1'b0, 1'b0);

    // Long hold: repeats at t+8, t+12, t+16, ...
    press_edge();
    expect_out("long_t0", 1'b1, 1'b0, 1'b0, 1'b1);
    check("long_count", 32'(press_count), 32'(exp_count));
    for (int i = 1; i <= 30; i++) begin
      tick();
      expect_out($sformatf("long_t%0d", i), 1'b0, 1'b0,
                 (i >= 8) && (((i - 8) % 4) == 0), 1'b1);
    end
    level = 1'b0;
    tick();
    expect_out("long_release", 1'b0, 1'b1, 1'b0, 1'b0);
    check("long_release_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();

    // Release on the terminal-count edge: release wins, no repeat.
    press_edge();
    expect_out("tie_t0", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      expect_out($sformatf("tie_t%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    level = 1'b0;
    tick();
    expect_out("tie_t8", 1'b0, 1'b1, 1'b0, 1'b0);
    check("tie_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    expect_out("tie_t9", 1'b0, 1'b0, 1'b0, 1'b0);

    // Minimum press: one high cycle -> press then release next cycle.
    press_edge();
    level = 1'b0;
    expect_out("min_press", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("min_release", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // 257 short presses: count wraps, 257 press and 257 release pulses.
    press_seen   = 0;
    release_seen = 0;
    for (int k = 0; k < 257; k++) begin
      press_edge();
      tick();
      level = 1'b0;
      tick();
      tick();
    end
    check("wrap_count", 32'(press_count), 32'(exp_count));
    check("wrap_presses", 32'(press_seen), 32'd257);
    check("wrap_releases", 32'(release_seen), 32'd257);

    // Async reset in the middle of REPEAT.
    press_edge();
    for (int i = 1; i <= 10; i++) tick();
    check("pre_reset_held", 32'(held), 32'd1);
    check("pre_reset_state", 32'(state_dbg), 32'(2'b10));
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("async_reset_count", 32'(press_count), 32'd0);
    check("async_reset_state", 32'(state_dbg), 32'(ST_IDLE));
    exp_count = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("post_reset_high", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    level = 1'b0;
    tick();
    expect_out("post_reset_low", 1'b0, 1'b0, 1'b0, 1'b0);
    press_edge();
    expect_out("post_reset_press", 1'b1, 1'b0, 1'b0, 1'b1);
    check("post_reset_count", 32'(press_count), 32'(exp_count));
    level = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
